// File: rtl/comb_bool_kmap0.sv
// comb_bool_kmap0: 2-input Boolean function defined by a 2x2 Karnaugh map.
// f = KMAP[{a,b}]. The output is purely combinational. clk and reset are
// carried only so that the block fits into clocked shells uniformly.
module comb_bool_kmap0 #(
  parameter logic [3:0] KMAP = 4'b1101
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic f
);

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CELL_N = 4;

  logic [SEL_W-1:0]  cell_sel;
  logic [CELL_N-1:0] cell_hot;
  logic              unused_pins;

  // a is the map row (MSB of the index) and b is the map column (LSB).
  assign cell_sel = {a, b};

  // One-hot decode of the addressed map cell, then gate it with the map contents.
  always_comb begin
    cell_hot = '0;
    for (int unsigned i = 0; i < CELL_N; i++) begin
      cell_hot[i] = (cell_sel == SEL_W'(i));
    end
    f = |(cell_hot & KMAP);
  end

  // The clock and reset pins have no function inside this block.
  assign unused_pins = ^{clk, reset};

endmodule

// File: tb/tb_comb_bool_kmap0.sv
// Testbench for comb_bool_kmap0: table-driven checks over several K-maps,
// plus reset-pulse sequences that must leave f undisturbed.
module tb_comb_bool_kmap0;

  logic clk;
  logic reset;
  logic a;
  logic b;
  logic f_def;
  logic f_xor;
  logic f_and;
  logic f_anb;

  int total;
  int bad;

  typedef struct {
    logic a;
    logic b;
    logic exp_def;
    logic exp_xor;
    logic exp_and;
    logic exp_anb;
  } vec_t;

  vec_t vecs [8];

  comb_bool_kmap0 dut_def (
    .clk(clk), .reset(reset), .a(a), .b(b), .f(f_def)
  );

  comb_bool_kmap0 #(.KMAP(4'b0110)) dut_xor (
    .clk(clk), .reset(reset), .a(a), .b(b), .f(f_xor)
  );

  comb_bool_kmap0 #(.KMAP(4'b1000)) dut_and (
    .clk(clk), .reset(reset), .a(a), .b(b), .f(f_and)
  );

  comb_bool_kmap0 #(.KMAP(4'b0100)) dut_anb (
    .clk(clk), .reset(reset), .a(a), .b(b), .f(f_anb)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (a=%b b=%b reset=%b)",
               name, act, exp, a, b, reset);
    end
  endtask

  // Drive 1 unit after the rising edge, then wait until 8 units later to sample.
  task automatic drive(input logic na, input logic nb, input logic nrst);
    @(posedge clk);
    #1;
    a     = na;
    b     = nb;
    reset = nrst;
    #8;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    a     = 1'b0;
    b     = 1'b0;
    reset = 1'b1;

    // Hand-computed expectations:
    //   default 1101 -> a | ~b ; 0110 -> a ^ b ; 1000 -> a & b ; 0100 -> a & ~b
    vecs[0] = '{a:1'b0, b:1'b0, exp_def:1'b1, exp_xor:1'b0, exp_and:1'b0, exp_anb:1'b0};
    vecs[1] = '{a:1'b0, b:1'b1, exp_def:1'b0, exp_xor:1'b1, exp_and:1'b0, exp_anb:1'b0};
    vecs[2] = '{a:1'b1, b:1'b0, exp_def:1'b1, exp_xor:1'b1, exp_and:1'b0, exp_anb:1'b1};
    vecs[3] = '{a:1'b1, b:1'b1, exp_def:1'b1, exp_xor:1'b0, exp_and:1'b1, exp_anb:1'b0};
    vecs[4] = '{a:1'b1, b:1'b1, exp_def:1'b1, exp_xor:1'b0, exp_and:1'b1, exp_anb:1'b0};
    vecs[5] = '{a:1'b0, b:1'b1, exp_def:1'b0, exp_xor:1'b1, exp_and:1'b0, exp_anb:1'b0};
    vecs[6] = '{a:1'b1, b:1'b0, exp_def:1'b1, exp_xor:1'b1, exp_and:1'b0, exp_anb:1'b1};
    vecs[7] = '{a:1'b0, b:1'b0, exp_def:1'b1, exp_xor:1'b0, exp_and:1'b0, exp_anb:1'b0};

    // Reset sequence with a=b=0; f must already be valid while reset is high.
    drive(1'b0, 1'b0, 1'b1);
    check("reset_state_def", f_def, 1'b1);
    check("reset_state_xor", f_xor, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // Table sweep, including repeated and reversed orderings.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].a, vecs[i].b, 1'b0);
      check($sformatf("vec%0d_def", i), f_def, vecs[i].exp_def);
      check($sformatf("vec%0d_xor", i), f_xor, vecs[i].exp_xor);
      check($sformatf("vec%0d_and", i), f_and, vecs[i].exp_and);
      check($sformatf("vec%0d_anb", i), f_anb, vecs[i].exp_anb);
    end

    // Hold a=b=0 and pulse reset for two cycles: f stays 1 throughout.
    drive(1'b0, 1'b0, 1'b0);
    check("hold_pre_reset", f_def, 1'b1);
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 1'b1);
      check($sformatf("hold_reset_cyc%0d", c), f_def, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0);
    check("hold_post_reset", f_def, 1'b1);

    // Reset asserted mid-sequence while inputs keep changing: f still tracks a,b.
    drive(1'b0, 1'b1, 1'b1);
    check("mid_reset_01_def", f_def, 1'b0);
    check("mid_reset_01_xor", f_xor, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    check("mid_reset_11_def", f_def, 1'b1);
    check("mid_reset_11_and", f_and, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    check("post_reset_10_anb", f_anb, 1'b1);
    check("post_reset_10_def", f_def, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
